// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter: pipeline
// payloads and the round-robin pick function.
package mul_share_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned PROD_W  = 2 * DATA_W;
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned TAG_W   = $clog2(MAX_REQ);

   typedef struct packed {
      logic signed [DATA_W-1:0] a;
      logic signed [DATA_W-1:0] b;
      logic [TAG_W-1:0]         id;
   } s1_t;

   typedef struct packed {
      logic signed [PROD_W-1:0] p;
      logic [TAG_W-1:0]         id;
   } s2_t;

   // First valid requester at or after ptr, searching cyclically over n slots.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [TAG_W-1:0]   ptr,
                                                  input int unsigned        n);
      logic [MAX_REQ-1:0] grant;
      logic               found;
      logic [TAG_W-1:0]   idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = TAG_W'((32'(ptr) + i) % n);
         if (i < n && !found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/Multiplier_top.sv
// 16x16 signed multiplier core: radix-4 Booth recoding, partial products
// summed combinationally (the adder tree is left to synthesis).
module Multiplier_top
   import mul_share_pkg::*;
(
   input  logic signed [DATA_W-1:0] Multiplier,
   input  logic signed [DATA_W-1:0] Multiplicant,
   output logic signed [PROD_W-1:0] result
);

   localparam int unsigned NPP = DATA_W / 2;

   logic [DATA_W:0]          rec;
   logic signed [PROD_W-1:0] md;
   logic signed [PROD_W-1:0] pp;
   logic signed [PROD_W-1:0] acc;

   always_comb begin
      rec = {Multiplier, 1'b0};
      md  = PROD_W'(Multiplicant);
      pp  = '0;
      acc = '0;
      for (int unsigned j = 0; j < NPP; j++) begin
         case (rec[2*j +: 3])
            3'b001, 3'b010: pp = md;
            3'b011:         pp = md <<< 1;
            3'b100:         pp = -(md <<< 1);
            3'b101, 3'b110: pp = -md;
            default:        pp = '0;
         endcase
         acc = acc + (pp <<< (2 * j));
      end
      result = acc;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or
// after ptr, suppressed entirely when en is low.
module rr_arbiter
   import mul_share_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   logic [MAX_REQ-1:0] pick;
   logic               unused_pick;

   always_comb begin
      pick      = rr_pick(MAX_REQ'(valid), TAG_W'(ptr), NUM_REQ);
      grant     = en ? pick[NUM_REQ-1:0] : '0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   // Slots above NUM_REQ are never valid; fold them away.
   assign unused_pick = ^pick;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one signed multiplier core among NUM_REQ requesters: round-robin
// issue into a two-stage pipeline, products returned in grant order with ID.
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [PROD_W-1:0]         rsp_data,
   output logic                      busy
);

   logic                     s1_valid_q, s1_valid_d;
   logic                     s2_valid_q, s2_valid_d;
   logic                     busy_q, busy_d;
   s1_t                      s1_q, s1_d;
   s2_t                      s2_q, s2_d;
   logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;

   logic                     s1_adv_c, s2_adv_c;
   logic [NUM_REQ-1:0]       grant_c;
   logic [ID_W-1:0]          grant_idx_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [DATA_W-1:0] op_a_c [NUM_REQ];
   logic signed [DATA_W-1:0] op_b_c [NUM_REQ];
   logic                     unused_tag;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_a_c[i] = req_a[i*DATA_W +: DATA_W];
      assign op_b_c[i] = req_b[i*DATA_W +: DATA_W];
   end

   assign s2_adv_c = !s2_valid_q || rsp_ready;
   assign s1_adv_c = !s1_valid_q || s2_adv_c;

   // Grants are withheld during reset so nothing is accepted and then dropped.
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .valid     (req_valid),
      .ptr       (rr_ptr_q),
      .en        (s1_adv_c && !rst),
      .grant     (grant_c),
      .grant_idx (grant_idx_c)
   );

   Multiplier_top u_mul (
      .Multiplier   (s1_q.a),
      .Multiplicant (s1_q.b),
      .result       (prod_c)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      rr_ptr_d   = rr_ptr_q;

      if (s1_adv_c) s1_valid_d = |grant_c;
      if (|grant_c) begin
         s1_d.a   = op_a_c[grant_idx_c];
         s1_d.b   = op_b_c[grant_idx_c];
         s1_d.id  = TAG_W'(grant_idx_c);
         rr_ptr_d = (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
      end

      if (s2_adv_c) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_d.p  = prod_c;
            s2_d.id = s1_q.id;
         end
      end

      busy_d = s1_valid_d || s2_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rr_ptr_q   <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         busy_q     <= busy_d;
         rr_ptr_q   <= rr_ptr_d;
         s2_q       <= s2_d;
      end
   end

   // Operand register is qualified by s1_valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

   assign req_ready  = grant_c;
   assign rsp_valid  = s2_valid_q;
   assign rsp_id     = ID_W'(s2_q.id);
   assign rsp_data   = s2_q.p;
   assign busy       = busy_q;
   assign unused_tag = ^s2_q.id;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and scoreboarded checks for mul_share_arbiter.
module tb_mul_share_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned NRAND = 10000;
   localparam int unsigned CMAX  = 60000;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*DW-1:0] req_a;
   logic [N*DW-1:0] req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_data;
   logic          busy;

   int            nchk = 0;
   int            nerr = 0;
   logic          auto_drop;

   always #5 clk = ~clk;

   mul_share_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
      req_a[k*DW +: DW] = a;
      req_b[k*DW +: DW] = b;
   endtask

   // Advance one clock; accepted requests are withdrawn when auto_drop is set.
   task automatic cyc();
      logic [N-1:0] acc;
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (auto_drop) req_valid = req_valid & ~acc;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   // One isolated request through an empty pipeline with rsp_ready high.
   task automatic single(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
      set_op(k, a, b);
      req_valid[k] = 1'b1;
      rsp_ready    = 1'b1;
      #1;
      chk("single_ready", req_ready, 64'(1 << k));
      cyc();
      chk("single_lat1_valid", rsp_valid, 0);
      cyc();
      chk("single_valid", rsp_valid, 1);
      chk("single_data", rsp_data, exp);
      chk("single_id", rsp_id, 64'(k));
      cyc();
   endtask

   logic [33:0]      sbq[$];
   logic [33:0]      sb_exp;
   logic [N-1:0]     racc;
   logic signed [15:0] ra, rb;
   logic signed [31:0] rp;
   int               issued;
   int               cycles;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      auto_drop = 1'b1;

      // Reset state, with requests presented during reset.
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b1;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      req_valid = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Single request, latency 2.
      set_op(0, 16'hFFFD, 16'h0007);
      req_valid = 4'b0001;
      #1;
      chk("t1_ready", req_ready, 4'b0001);
      cyc();
      chk("t1_lat1_valid", rsp_valid, 0);
      chk("t1_busy", busy, 1);
      cyc();
      chk("t1_valid", rsp_valid, 1);
      chk("t1_data", rsp_data, 32'hFFFFFFEB);
      chk("t1_id", rsp_id, 0);
      cyc();
      chk("t1_drained", rsp_valid, 0);

      // Arithmetic corners.
      single(1, 16'h8000, 16'h8000, 32'h40000000);
      single(2, 16'h7FFF, 16'h8000, 32'hC0008000);
      single(3, 16'h0000, 16'h1234, 32'h00000000);
      single(0, 16'hFFFF, 16'hFFFF, 32'h00000001);
      single(1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
      single(2, 16'h8000, 16'h0001, 32'hFFFF8000);

      // All requesters continuously valid: grants 0,1,2,3,0,...
      do_reset();
      for (int k = 0; k < N; k++) set_op(k, 16'(k + 1), 16'd10);
      rsp_ready = 1'b1;
      auto_drop = 1'b0;
      req_valid = '1;
      for (int c = 0; c < 7; c++) begin
         #1;
         chk("t3_grant", req_ready, 64'(1 << (c % 4)));
         if (c >= 2) begin
            chk("t3_valid", rsp_valid, 1);
            chk("t3_id", rsp_id, 64'((c - 2) % 4));
            chk("t3_data", rsp_data, 64'((((c - 2) % 4) + 1) * 10));
         end
         cyc();
      end
      req_valid = '0;
      auto_drop = 1'b1;
      repeat (3) cyc();

      // Backpressure with three queued requests.
      do_reset();
      rsp_ready = 1'b0;
      set_op(0, 16'd2, 16'hFFFB);
      set_op(1, 16'd3, 16'hFFFB);
      set_op(2, 16'd4, 16'hFFFB);
      req_valid = 4'b0111;
      #1;
      chk("t4_ready0", req_ready, 4'b0001);
      cyc();
      #1;
      chk("t4_ready1", req_ready, 4'b0010);
      chk("t4_valid_early", rsp_valid, 0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_stall_ready", req_ready, 0);
         chk("t4_stall_valid", rsp_valid, 1);
         chk("t4_stall_id", rsp_id, 0);
         chk("t4_stall_data", rsp_data, 32'hFFFFFFF6);
         chk("t4_pending", req_valid, 4'b0100);
         cyc();
      end
      rsp_ready = 1'b1;
      #1;
      chk("t4_release_ready", req_ready, 4'b0100);
      cyc();
      chk("t4_r1_valid", rsp_valid, 1);
      chk("t4_r1_id", rsp_id, 1);
      chk("t4_r1_data", rsp_data, 32'hFFFFFFF1);
      cyc();
      chk("t4_r2_valid", rsp_valid, 1);
      chk("t4_r2_id", rsp_id, 2);
      chk("t4_r2_data", rsp_data, 32'hFFFFFFEC);
      cyc();
      chk("t4_empty", rsp_valid, 0);
      chk("t4_idle", busy, 0);

      // Fairness between requesters 2 and 3 starting from rr_ptr=3.
      do_reset();
      single(2, 16'd3, 16'd3, 32'd9);
      set_op(3, 16'd5, 16'd5);
      auto_drop = 1'b0;
      req_valid = 4'b1100;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t5_grant", req_ready, (i % 2 == 0) ? 4'b1000 : 4'b0100);
         cyc();
      end
      req_valid = '0;
      auto_drop = 1'b1;
      repeat (3) cyc();

      // Reset with both stages full.
      do_reset();
      rsp_ready = 1'b0;
      set_op(0, 16'd2, 16'd3);
      set_op(1, 16'd4, 16'd5);
      req_valid = 4'b0011;
      #1;
      cyc();
      cyc();
      chk("t6_full_busy", busy, 1);
      chk("t6_full_valid", rsp_valid, 1);
      chk("t6_full_data", rsp_data, 32'd6);
      rst       = 1'b1;
      req_valid = '1;
      #1;
      chk("t6_rst_ready", req_ready, 0);
      cyc();
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rsp_data", rsp_data, 0);
      rst = 1'b0;
      #1;
      chk("t6_ptr0", req_ready, 4'b0001);
      req_valid = 4'b0010;
      set_op(1, 16'd6, 16'd7);
      rsp_ready = 1'b1;
      #1;
      chk("t6_req1_ready", req_ready, 4'b0010);
      cyc();
      cyc();
      chk("t6_valid", rsp_valid, 1);
      chk("t6_id", rsp_id, 1);
      chk("t6_data", rsp_data, 32'h2A);
      cyc();
      chk("t6_no_stale", rsp_valid, 0);

      // Random operands under random valid/ready against a scoreboard.
      do_reset();
      issued = 0;
      cycles = 0;
      while ((issued < NRAND || sbq.size() != 0 || busy || req_valid != '0) && cycles < CMAX) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k] && issued < NRAND && $urandom_range(1) == 0) begin
               set_op(k, 16'($urandom), 16'($urandom));
               req_valid[k] = 1'b1;
               issued++;
            end
         end
         rsp_ready = ($urandom_range(3) != 0);
         #1;
         racc = req_valid & req_ready;
         if (racc != '0) begin
            chk("rand_onehot", $countones(racc), 1);
            for (int k = 0; k < N; k++) begin
               if (racc[k]) begin
                  ra = req_a[k*DW +: DW];
                  rb = req_b[k*DW +: DW];
                  rp = ra * rb;
                  sbq.push_back({2'(k), rp});
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
               chk("rand_spurious", 1, 0);
            end else begin
               sb_exp = sbq.pop_front();
               chk("rand_id", rsp_id, sb_exp[33:32]);
               chk("rand_data", rsp_data, sb_exp[31:0]);
            end
         end
         @(posedge clk);
         #1;
         req_valid = req_valid & ~racc;
         @(negedge clk);
         cycles++;
      end
      chk("rand_timeout", cycles < CMAX, 1);
      chk("rand_sb_empty", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
